uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between two byte-stream requesters: req 0 is the result/output path and req 1 is the vector readback path.
- Arbitrates at packet granularity using round-robin. Once a packet is granted it is locked until its last byte.
- Sequences each byte through the UART: load, tx_start pulse, busy handshake, then inter-byte gap.
- Sits between the coprocessor output logic and the UART TX core.

Parameters:
- INTER_BYTE_DELAY, 1000: idle cycles after each byte completes. A value of 0 is treated as 1.
- BUSY_WAIT, 16: maximum cycles to wait for tx_busy to rise after tx_start.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid  in  2  per-requester byte available.
- req_data0  in  8  requester 0 byte.
- req_last0  in  1  requester 0 byte is the last of its packet.
- req_data1  in  8  requester 1 byte.
- req_last1  in  1  requester 1 byte is the last of its packet.
- req_ready  out  2  one-cycle pulse: byte of the granted requester consumed.
- tx_busy  in  1  UART transmitter busy.
- tx_start  out  1  one-cycle start pulse to the UART.
- tx_data  out  8  byte to the UART, held stable from LOAD until the next LOAD.
- grant  out  2  one-hot owner of the UART; 00 when idle.
- pkt_done  out  1  one-cycle pulse after the last byte's gap completes.
- timeout_err  out  1  one-cycle pulse when tx_busy never rose within BUSY_WAIT.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - tx_start, req_ready, grant, pkt_done, timeout_err, tx_data all 0.
  - Counters 0; last_grant=1, so requester 0 wins the first tie.
  - Reset mid-packet aborts immediately: no pkt_done, no tx_start.
- IDLE:
  - If any req_valid bit is set, pick the winner and register grant.
  - With both valid, the requester not equal to last_grant wins; with one valid, that one wins.
  - Transition to LOAD.
  - A request arriving in the same cycle as a pkt_done-triggered return is arbitrated on the following IDLE cycle.
- LOAD:
  - If req_valid[g]: pulse req_ready[g], latch tx_data=req_data_g and last_flag=req_last_g, go to START.
  - Else stay in LOAD with the grant held. A requester may stall mid-packet indefinitely.
- START:
  - If tx_busy=0: tx_start=1 for exactly one cycle, clear busy counter, go to WAIT_BUSY.
  - Else hold in START with no pulse.
- WAIT_BUSY:
  - If tx_busy=1, go to WAIT_DONE.
  - Else increment the counter. When it reaches BUSY_WAIT: pulse timeout_err, go to GAP (the byte is considered sent).
- WAIT_DONE: wait for tx_busy=0, then go to GAP.
- GAP:
  - Count max(INTER_BYTE_DELAY,1) cycles.
  - At the end, if last_flag: pulse pkt_done, set last_grant=g, grant=00, go to IDLE.
  - Otherwise go to LOAD.
- Locking: req_valid of the non-granted requester is ignored for the whole packet, with no req_ready to it.
- Latency:
  - req_valid seen in IDLE at cycle t → grant at t+1, req_ready at t+1 (LOAD).
  - tx_start at t+2 when tx_busy=0.
- Invariants:
  - grant is one-hot or zero.
  - req_ready is only ever asserted on the granted bit.
  - At most one tx_start per consumed byte.

Test Plan:
Bench uses INTER_BYTE_DELAY=2 and BUSY_WAIT=4; the UART model raises tx_busy 1 cycle after tx_start and holds it 3 cycles.
1. Single 4-byte packet on req 0 (0x12,0x34,0x56,0x78, last on 0x78) → exactly 4 tx_start pulses carrying those tx_data values in order, grant=01 throughout, one pkt_done after the final gap, then grant=00.
2. Both requesters valid from reset, each with a 2-byte packet (0xA1,0xA2 and 0xB1,0xB2) → order A1 A2 B1 B2. Then a repeated simultaneous request → requester 1 first (round-robin).
3. Req 1 asserts valid mid-packet of req 0 → no req_ready[1] until req 0's pkt_done; req 1's packet starts on the next IDLE arbitration.
4. UART model never raises tx_busy → timeout_err pulse 4 cycles after tx_start; sequence continues to the next byte and pkt_done still occurs.
5. tx_busy held 1 when entering START → no tx_start until tx_busy drops, then a single pulse.
6. reset=0 asserted during WAIT_DONE of byte 2 → all outputs 0 immediately, no pkt_done. After release, a new packet transmits from its first byte normally.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-level round-robin arbiter sharing one UART transmitter
// Two byte-stream requesters; a granted packet owns the UART until its last byte's gap completes.
`timescale 1ns/1ps
module uart_tx_arbiter #(
   parameter int INTER_BYTE_DELAY = 1000,
   parameter int BUSY_WAIT        = 16
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic [1:0] req_valid_i,
   input  logic [7:0] req_data0_i,
   input  logic       req_last0_i,
   input  logic [7:0] req_data1_i,
   input  logic       req_last1_i,
   output logic [1:0] req_ready_o,
   input  logic       tx_busy_i,
   output logic       tx_start_o,
   output logic [7:0] tx_data_o,
   output logic [1:0] grant_o,
   output logic       pkt_done_o,
   output logic       timeout_err_o
);

   localparam int GAP_CYCLES = (INTER_BYTE_DELAY < 1) ? 1 : INTER_BYTE_DELAY;
   localparam int BUSY_LIMIT = (BUSY_WAIT < 1) ? 1 : BUSY_WAIT;
   localparam int GAP_W      = $clog2(GAP_CYCLES + 1);
   localparam int BUSY_W     = $clog2(BUSY_LIMIT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        grant_q, grant_d;
   logic              last_grant_q, last_grant_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              last_q, last_d;
   logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

   logic              sel_valid;
   logic [7:0]        sel_data;
   logic              sel_last;

   // grant_q is one-hot while a packet is active, so bit 1 alone selects the owner
   assign sel_valid = grant_q[1] ? req_valid_i[1] : req_valid_i[0];
   assign sel_data  = grant_q[1] ? req_data1_i    : req_data0_i;
   assign sel_last  = grant_q[1] ? req_last1_i    : req_last0_i;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= S_IDLE;
         grant_q      <= 2'b00;
         last_grant_q <= 1'b1;
         tx_data_q    <= 8'h00;
         last_q       <= 1'b0;
         busy_cnt_q   <= '0;
         gap_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         tx_data_q    <= tx_data_d;
         last_q       <= last_d;
         busy_cnt_q   <= busy_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      tx_data_d     = tx_data_q;
      last_d        = last_q;
      busy_cnt_d    = busy_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      req_ready_o   = 2'b00;
      tx_start_o    = 1'b0;
      pkt_done_o    = 1'b0;
      timeout_err_o = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (req_valid_i != 2'b00) begin
               // on a tie the requester that did not own the last packet wins
               if (req_valid_i == 2'b11) grant_d = last_grant_q ? 2'b01 : 2'b10;
               else                      grant_d = req_valid_i;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (sel_valid) begin
               req_ready_o = grant_q;
               tx_data_d   = sel_data;
               last_d      = sel_last;
               state_d     = S_START;
            end
         end
         S_START: begin
            if (!tx_busy_i) begin
               tx_start_o = 1'b1;
               busy_cnt_d = '0;
               state_d    = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            if (tx_busy_i) begin
               state_d = S_WAIT_DONE;
            end else if (busy_cnt_q == BUSY_W'(BUSY_LIMIT - 1)) begin
               // the UART never acknowledged; treat the byte as sent and move on
               timeout_err_o = 1'b1;
               gap_cnt_d     = '0;
               state_d       = S_GAP;
            end else begin
               busy_cnt_d = busy_cnt_q + BUSY_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy_i) begin
               gap_cnt_d = '0;
               state_d   = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
               if (last_q) begin
                  pkt_done_o   = 1'b1;
                  last_grant_d = grant_q[1];
                  grant_d      = 2'b00;
                  state_d      = S_IDLE;
               end else begin
                  state_d = S_LOAD;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign tx_data_o = tx_data_q;
   assign grant_o   = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
// A small UART model answers tx_start; expected {grant, byte} pairs are queued and popped on tx_start.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int IBD = 2;
   localparam int BW  = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       v0 = 1'b0, v1 = 1'b0;
   logic [7:0] d0 = 8'h00, d1 = 8'h00;
   logic       l0 = 1'b0, l1 = 1'b0;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [1:0] grant;
   logic       pkt_done;
   logic       timeout_err;

   int tests_run = 0;
   int tests_failed = 0;

   assign req_valid = {v1, v0};

   uart_tx_arbiter #(.INTER_BYTE_DELAY(IBD), .BUSY_WAIT(BW)) dut (
      .clk_i(clk), .reset_ni(reset_n),
      .req_valid_i(req_valid),
      .req_data0_i(d0), .req_last0_i(l0),
      .req_data1_i(d1), .req_last1_i(l1),
      .req_ready_o(req_ready),
      .tx_busy_i(tx_busy), .tx_start_o(tx_start), .tx_data_o(tx_data),
      .grant_o(grant), .pkt_done_o(pkt_done), .timeout_err_o(timeout_err)
   );

   always #5 clk = ~clk;

   // UART model: busy rises the cycle after tx_start and stays up for 3 cycles
   logic uart_dead = 1'b0;
   logic force_busy = 1'b0;
   int   ucnt;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)                   ucnt <= 0;
      else if (tx_start && !uart_dead) ucnt <= 3;
      else if (ucnt > 0)              ucnt <= ucnt - 1;
   end
   assign tx_busy = (ucnt > 0) || force_busy;

   logic [9:0] exp_q[$];
   int cyc = 0;
   int n_start = 0, n_done = 0, n_to = 0;
   int last_start_cyc = 0, last_done_cyc = 0, last_to_cyc = 0;
   int first_done_cyc = -1, first_rdy1_cyc = -1;
   logic abort = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [9:0] e;
      tests_run++;
      if (!(grant == 2'b00 || grant == 2'b01 || grant == 2'b10)) begin
         tests_failed++;
         $display("FAIL grant_onehot: grant=%b required one-hot or 00", grant);
      end
      tests_run++;
      if ((req_ready & ~grant) !== 2'b00) begin
         tests_failed++;
         $display("FAIL ready_on_grant: req_ready=%b grant=%b required ready within grant", req_ready, grant);
      end
      if (tx_start) begin
         n_start++;
         last_start_cyc = cyc;
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL tx_byte: tx_start with grant=%b data=%h, none expected", grant, tx_data);
         end else begin
            e = exp_q.pop_front();
            if ({grant, tx_data} !== e) begin
               tests_failed++;
               $display("FAIL tx_byte: grant=%b data=%h required grant=%b data=%h", grant, tx_data, e[9:8], e[7:0]);
            end
         end
      end
      if (pkt_done) begin
         n_done++;
         last_done_cyc = cyc;
         if (first_done_cyc < 0) first_done_cyc = cyc;
      end
      if (timeout_err) begin
         n_to++;
         last_to_cyc = cyc;
      end
      if (req_ready[1] && first_rdy1_cyc < 0) first_rdy1_cyc = cyc;
   end

   task automatic drive_pkt(input int r, input logic [7:0] b0, b1, b2, b3, input int n);
      logic [7:0] b[4];
      bit got;
      b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
      for (int k = 0; k < n; k++) begin
         got = 1'b0;
         if (r == 0) begin v0 = 1'b1; d0 = b[k]; l0 = (k == n - 1); end
         else        begin v1 = 1'b1; d1 = b[k]; l1 = (k == n - 1); end
         for (int i = 0; i < 400 && !got && !abort; i++) begin
            @(negedge clk);
            if ((r == 0) ? req_ready[0] : req_ready[1]) got = 1'b1;
         end
         if (abort) break;
         tests_run++;
         if (!got) begin
            tests_failed++;
            $display("FAIL req_ready_wait: requester %0d byte %0d ready=0 required 1", r, k);
         end
         @(posedge clk); #1;
      end
      if (r == 0) begin v0 = 1'b0; d0 = 8'h00; l0 = 1'b0; end
      else        begin v1 = 1'b0; d1 = 8'h00; l1 = 1'b0; end
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 2000 && n_done < target; i++) @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++; if (grant !== 2'b00)      begin tests_failed++; $display("FAIL reset_grant: %b required 00", grant); end
      tests_run++; if (tx_start !== 1'b0)    begin tests_failed++; $display("FAIL reset_tx_start: %b required 0", tx_start); end
      tests_run++; if (req_ready !== 2'b00)  begin tests_failed++; $display("FAIL reset_req_ready: %b required 00", req_ready); end
      tests_run++; if (pkt_done !== 1'b0)    begin tests_failed++; $display("FAIL reset_pkt_done: %b required 0", pkt_done); end
      tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout: %b required 0", timeout_err); end
      tests_run++; if (tx_data !== 8'h00)    begin tests_failed++; $display("FAIL reset_tx_data: %h required 00", tx_data); end
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_packet();
      int bd, bs;
      bd = n_done; bs = n_start;
      exp_q.push_back({2'b01, 8'h12}); exp_q.push_back({2'b01, 8'h34});
      exp_q.push_back({2'b01, 8'h56}); exp_q.push_back({2'b01, 8'h78});
      fork
         drive_pkt(0, 8'h12, 8'h34, 8'h56, 8'h78, 4);
         begin
            @(negedge clk);
            tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL lat_idle_grant: %b required 00", grant); end
            @(negedge clk);
            tests_run++; if (grant !== 2'b01 || req_ready !== 2'b01) begin
               tests_failed++; $display("FAIL lat_load: grant=%b ready=%b required 01/01", grant, req_ready); end
            @(negedge clk);
            tests_run++; if (tx_start !== 1'b1) begin tests_failed++; $display("FAIL lat_start: tx_start=%b required 1", tx_start); end
         end
      join
      wait_done(bd + 1);
      tests_run++; if (n_done !== bd + 1) begin tests_failed++; $display("FAIL single_done: %0d required %0d", n_done - bd, 1); end
      tests_run++; if (n_start !== bs + 4) begin tests_failed++; $display("FAIL single_starts: %0d required 4", n_start - bs); end
      tests_run++; if (last_done_cyc - last_start_cyc !== 6) begin
         tests_failed++; $display("FAIL single_done_lat: %0d required 6", last_done_cyc - last_start_cyc); end
      @(negedge clk);
      tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL single_grant_after: %b required 00", grant); end
   endtask

   task automatic test_round_robin();
      int bd;
      bd = n_done;
      exp_q.push_back({2'b01, 8'hA1}); exp_q.push_back({2'b01, 8'hA2});
      exp_q.push_back({2'b10, 8'hB1}); exp_q.push_back({2'b10, 8'hB2});
      exp_q.push_back({2'b01, 8'hC1}); exp_q.push_back({2'b01, 8'hC2});
      reset_n = 1'b0;
      fork
         begin
            drive_pkt(0, 8'hA1, 8'hA2, 8'h00, 8'h00, 2);
            drive_pkt(0, 8'hC1, 8'hC2, 8'h00, 8'h00, 2);
         end
         drive_pkt(1, 8'hB1, 8'hB2, 8'h00, 8'h00, 2);
         begin repeat (2) @(negedge clk); reset_n = 1'b1; end
      join
      wait_done(bd + 3);
      tests_run++; if (n_done !== bd + 3) begin tests_failed++; $display("FAIL rr_done: %0d required 3", n_done - bd); end
      bd = n_done;
      exp_q.push_back({2'b10, 8'hE1}); exp_q.push_back({2'b10, 8'hE2});
      exp_q.push_back({2'b01, 8'hD1}); exp_q.push_back({2'b01, 8'hD2});
      fork
         drive_pkt(0, 8'hD1, 8'hD2, 8'h00, 8'h00, 2);
         drive_pkt(1, 8'hE1, 8'hE2, 8'h00, 8'h00, 2);
      join
      wait_done(bd + 2);
      tests_run++; if (n_done !== bd + 2) begin tests_failed++; $display("FAIL rr2_done: %0d required 2", n_done - bd); end
      tests_run++; if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL rr_left: %0d bytes pending required 0", exp_q.size()); end
   endtask

   task automatic test_lock();
      int bd;
      bd = n_done;
      first_done_cyc = -1; first_rdy1_cyc = -1;
      exp_q.push_back({2'b01, 8'h41}); exp_q.push_back({2'b01, 8'h42});
      exp_q.push_back({2'b01, 8'h43}); exp_q.push_back({2'b01, 8'h44});
      exp_q.push_back({2'b10, 8'h51}); exp_q.push_back({2'b10, 8'h52});
      fork
         drive_pkt(0, 8'h41, 8'h42, 8'h43, 8'h44, 4);
         begin repeat (12) @(negedge clk); drive_pkt(1, 8'h51, 8'h52, 8'h00, 8'h00, 2); end
      join
      wait_done(bd + 2);
      tests_run++; if (n_done !== bd + 2) begin tests_failed++; $display("FAIL lock_done: %0d required 2", n_done - bd); end
      tests_run++; if (first_rdy1_cyc !== first_done_cyc + 2) begin
         tests_failed++; $display("FAIL lock_ready1: first ready1 at %0d required %0d", first_rdy1_cyc, first_done_cyc + 2); end
   endtask

   task automatic test_timeout();
      int bd, bt;
      bd = n_done; bt = n_to;
      uart_dead = 1'b1;
      exp_q.push_back({2'b01, 8'h9A}); exp_q.push_back({2'b01, 8'h9B});
      drive_pkt(0, 8'h9A, 8'h9B, 8'h00, 8'h00, 2);
      wait_done(bd + 1);
      uart_dead = 1'b0;
      tests_run++; if (n_to !== bt + 2) begin tests_failed++; $display("FAIL to_count: %0d required 2", n_to - bt); end
      tests_run++; if (n_done !== bd + 1) begin tests_failed++; $display("FAIL to_done: %0d required 1", n_done - bd); end
      tests_run++; if (last_to_cyc - last_start_cyc !== BW) begin
         tests_failed++; $display("FAIL to_latency: %0d required %0d", last_to_cyc - last_start_cyc, BW); end
   endtask

   task automatic test_busy_hold();
      int bd, bs;
      bd = n_done; bs = n_start;
      force_busy = 1'b1;
      exp_q.push_back({2'b01, 8'h77});
      fork
         drive_pkt(0, 8'h77, 8'h00, 8'h00, 8'h00, 1);
         begin
            repeat (10) @(negedge clk);
            tests_run++; if (n_start !== bs) begin tests_failed++; $display("FAIL hold_no_start: %0d starts required 0", n_start - bs); end
            force_busy = 1'b0;
         end
      join
      wait_done(bd + 1);
      tests_run++; if (n_start !== bs + 1) begin tests_failed++; $display("FAIL hold_one_start: %0d required 1", n_start - bs); end
      tests_run++; if (n_done !== bd + 1) begin tests_failed++; $display("FAIL hold_done: %0d required 1", n_done - bd); end
   endtask

   task automatic test_reset_mid();
      int bd, seen;
      bd = n_done; seen = 0;
      exp_q.push_back({2'b01, 8'h11}); exp_q.push_back({2'b01, 8'h22});
      fork
         drive_pkt(0, 8'h11, 8'h22, 8'h33, 8'h44, 4);
         begin
            for (int i = 0; i < 200 && seen < 2; i++) begin
               @(negedge clk);
               if (tx_start) seen++;
            end
            tests_run++; if (seen !== 2) begin tests_failed++; $display("FAIL mid_starts: %0d required 2", seen); end
            repeat (2) @(negedge clk);
            reset_n = 1'b0; abort = 1'b1;
            #1;
            tests_run++; if ({grant, req_ready, tx_start, pkt_done, timeout_err, tx_data} !== 15'h0) begin
               tests_failed++; $display("FAIL mid_reset_out: grant=%b ready=%b start=%b done=%b to=%b data=%h required all 0",
                  grant, req_ready, tx_start, pkt_done, timeout_err, tx_data); end
            repeat (3) @(negedge clk);
            tests_run++; if (n_done !== bd) begin tests_failed++; $display("FAIL mid_no_done: %0d required 0", n_done - bd); end
            reset_n = 1'b1;
         end
      join
      abort = 1'b0;
      tests_run++; if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL mid_left: %0d pending required 0", exp_q.size()); end
      @(posedge clk); #1;
      exp_q.push_back({2'b01, 8'h5A}); exp_q.push_back({2'b01, 8'h5B});
      drive_pkt(0, 8'h5A, 8'h5B, 8'h00, 8'h00, 2);
      wait_done(bd + 1);
      tests_run++; if (n_done !== bd + 1) begin tests_failed++; $display("FAIL mid_after_done: %0d required 1", n_done - bd); end
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_round_robin();
      test_lock();
      test_timeout();
      test_busy_hold();
      test_reset_mid();
      repeat (4) @(negedge clk);
      tests_run++;
      if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL final_left: %0d pending required 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
